alu_pwr_ctrl: RTL

Power-sequencing controller for the power-gated ALU domain, sitting directly upstream of the ALU wrapper. It drives the ALU's `alu_pwr_en`, `iso_en` and a domain reset, handshakes with the power switch, and keeps the domain powered only while there is work. Isolation is always asserted before power is removed and released only after the domain is powered and out of reset.

---
 rtl/alu_pwr_ctrl_if.sv | 40 ++++
 rtl/alu_pwr_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu_pwr_ctrl_if.sv
// ---------------------------------------------------------------------------
// alu_pwr_ctrl_if
// Bundles the request/handshake inputs and the power-control outputs of the
// ALU power-sequencing controller.
//   master : upstream requesters / power switch / testbench side
//            (drives requests, alu_busy and pwr_ack; observes controls)
//   slave  : the controller itself
// Signals:
//   wake_req, sleep_req, start_req   power requests (levels)
//   alu_busy                         ALU operation in flight
//   pwr_ack                          power-switch good (1 = rail up)
//   alu_pwr_en, iso_en, alu_rst_n    power switch enable, clamp enable,
//                                    active-low domain reset
//   ready                            ALU may accept start
//   pwr_fault                        switch handshake timed out
//   state_obs[2:0]                   current state encoding
// ---------------------------------------------------------------------------
interface alu_pwr_ctrl_if;
  logic       wake_req;
  logic       sleep_req;
  logic       start_req;
  logic       alu_busy;
  logic       pwr_ack;
  logic       alu_pwr_en;
  logic       iso_en;
  logic       alu_rst_n;
  logic       ready;
  logic       pwr_fault;
  logic [2:0] state_obs;

  modport master (
    output wake_req, sleep_req, start_req, alu_busy, pwr_ack,
    input  alu_pwr_en, iso_en, alu_rst_n, ready, pwr_fault, state_obs
  );

  modport slave (
    input  wake_req, sleep_req, start_req, alu_busy, pwr_ack,
    output alu_pwr_en, iso_en, alu_rst_n, ready, pwr_fault, state_obs
  );
endinterface

// File: rtl/alu_pwr_ctrl.sv
// ---------------------------------------------------------------------------
// alu_pwr_ctrl
// Power-sequencing controller for the power-gated ALU domain. Powers the
// domain up (switch enable, wait for pwr_ack, hold domain reset, hold
// isolation) and down (drain, set isolation, drop switch, wait for pwr_ack
// to fall). Isolation always covers the powered-off and in-reset windows.
//
// Ports:
//   clk   in  clock
//   rst   in  asynchronous active-high reset (forces OFF outputs at once)
//   bus   alu_pwr_ctrl_if.slave : requests, alu_busy, pwr_ack in;
//         alu_pwr_en, iso_en, alu_rst_n, ready, pwr_fault, state_obs out
//
// Build option:
//   ALU_PWR_AUTO_SLEEP_EN  when defined, ON falls into DRAIN after
//                          IDLE_CYCLES consecutive idle cycles.
// ---------------------------------------------------------------------------
module alu_pwr_ctrl #(
  parameter int ISO_SETUP   = 2,
  parameter int RST_CYCLES  = 4,
  parameter int ISO_HOLD    = 2,
  parameter int ACK_TIMEOUT = 64,
  parameter int IDLE_CYCLES = 256
) (
  input logic          clk,
  input logic          rst,
  alu_pwr_ctrl_if.slave bus
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_PARAM = max2(max2(max2(ISO_SETUP, RST_CYCLES), max2(ISO_HOLD, ACK_TIMEOUT)),
                                  IDLE_CYCLES);
  localparam int CNT_W     = $clog2(MAX_PARAM) + 1;

  // Reload values: a timed state lasting N cycles counts N-1 .. 0.
  localparam logic [CNT_W-1:0] LD_ISO_SETUP = CNT_W'(ISO_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_RST       = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_ISO_HOLD  = CNT_W'(ISO_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_ACK       = CNT_W'(ACK_TIMEOUT - 1);
`ifdef ALU_PWR_AUTO_SLEEP_EN
  localparam logic [CNT_W-1:0] LD_IDLE      = CNT_W'(IDLE_CYCLES - 1);
`endif

  // FAULT lives on its own state bit; it reports 7 on state_obs and is told
  // apart from PWR_DN by pwr_fault.
  typedef enum logic [3:0] {
    S_OFF      = 4'd0,
    S_PWR_UP   = 4'd1,
    S_RST_HOLD = 4'd2,
    S_ISO_REL  = 4'd3,
    S_ON       = 4'd4,
    S_DRAIN    = 4'd5,
    S_ISO_SET  = 4'd6,
    S_PWR_DN   = 4'd7,
    S_FAULT    = 4'd8
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             pend_sleep_reg, pend_sleep_next;
  logic             pend_wake_reg, pend_wake_next;
  logic [7:0]       out_reg;
  logic             any_wake;

  // Output vector: {pwr_en, iso, rst_n, ready, fault, state_obs[2:0]}
  function automatic logic [7:0] decode(input state_t s);
    case (s)
      S_OFF:      decode = 8'b01000_000;
      S_PWR_UP:   decode = 8'b11000_001;
      S_RST_HOLD: decode = 8'b11000_010;
      S_ISO_REL:  decode = 8'b11100_011;
      S_ON:       decode = 8'b10110_100;
      S_DRAIN:    decode = 8'b10100_101;
      S_ISO_SET:  decode = 8'b11100_110;
      S_PWR_DN:   decode = 8'b01000_111;
      default:    decode = 8'b01001_111;  // FAULT
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] entry_load(input state_t s);
    case (s)
      S_PWR_UP,
      S_PWR_DN:   entry_load = LD_ACK;
      S_RST_HOLD: entry_load = LD_RST;
      S_ISO_REL:  entry_load = LD_ISO_HOLD;
      S_ISO_SET:  entry_load = LD_ISO_SETUP;
`ifdef ALU_PWR_AUTO_SLEEP_EN
      S_ON:       entry_load = LD_IDLE;
`endif
      default:    entry_load = '0;
    endcase
  endfunction

  assign any_wake = bus.wake_req | bus.start_req;

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    pend_sleep_next = pend_sleep_reg;
    pend_wake_next  = pend_wake_reg;

    case (state_reg)
      S_OFF: begin
        pend_wake_next = 1'b0;
        if (any_wake || pend_wake_reg) state_next = S_PWR_UP;
      end
      S_PWR_UP: begin
        if (bus.pwr_ack)         state_next = S_RST_HOLD;
        else if (cnt_reg == '0)  state_next = S_FAULT;
        else                     cnt_next   = cnt_reg - 1'b1;
      end
      S_RST_HOLD: begin
        if (cnt_reg == '0) state_next = S_ISO_REL;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      S_ISO_REL: begin
        if (cnt_reg == '0) state_next = S_ON;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      S_ON: begin
        // Wake/start win over a simultaneous sleep and cancel a pending one.
        if (any_wake) begin
          pend_sleep_next = 1'b0;
        end else if (bus.sleep_req || pend_sleep_reg) begin
          state_next      = S_DRAIN;
          pend_sleep_next = 1'b0;
        end
`ifdef ALU_PWR_AUTO_SLEEP_EN
        // The shared counter doubles as the idle timer while in ON.
        if (bus.alu_busy || any_wake) cnt_next   = LD_IDLE;
        else if (cnt_reg == '0)       state_next = S_DRAIN;
        else                          cnt_next   = cnt_reg - 1'b1;
`endif
      end
      S_DRAIN: begin
        if (!bus.alu_busy) state_next = S_ISO_SET;
      end
      S_ISO_SET: begin
        if (cnt_reg == '0) state_next = S_PWR_DN;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      S_PWR_DN: begin
        if (!bus.pwr_ack)        state_next = S_OFF;
        else if (cnt_reg == '0)  state_next = S_FAULT;
        else                     cnt_next   = cnt_reg - 1'b1;
      end
      default: begin
        // FAULT: sticky until rst.
        state_next      = S_FAULT;
        pend_sleep_next = 1'b0;
        pend_wake_next  = 1'b0;
      end
    endcase

    // Requests against a sequence in progress are remembered, never abort it.
    if (state_reg inside {S_PWR_UP, S_RST_HOLD, S_ISO_REL}) begin
      if (any_wake)           pend_sleep_next = 1'b0;
      else if (bus.sleep_req) pend_sleep_next = 1'b1;
    end
    if (state_reg inside {S_DRAIN, S_ISO_SET, S_PWR_DN}) begin
      if (any_wake)           pend_wake_next = 1'b1;
      else if (bus.sleep_req) pend_wake_next = 1'b0;
    end

    if (state_next != state_reg) cnt_next = entry_load(state_next);
  end

  // Outputs are registered from the next-state decode so they switch on the
  // same edge as the state without any combinational path to the pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_OFF;
      cnt_reg        <= '0;
      pend_sleep_reg <= 1'b0;
      pend_wake_reg  <= 1'b0;
      out_reg        <= 8'b01000_000;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      pend_sleep_reg <= pend_sleep_next;
      pend_wake_reg  <= pend_wake_next;
      out_reg        <= decode(state_next);
    end
  end

  assign bus.alu_pwr_en = out_reg[7];
  assign bus.iso_en     = out_reg[6];
  assign bus.alu_rst_n  = out_reg[5];
  assign bus.ready      = out_reg[4];
  assign bus.pwr_fault  = out_reg[3];
  assign bus.state_obs  = out_reg[2:0];

endmodule
